// File: rtl/sqrt_issue_ctrl.sv
// sqrt_issue_ctrl: upstream sequencer for the 8-bit iterative square-root core.
//
// It accepts one operand at a time on a valid/ready input stream and holds it
// stable on core_dt_o. It enables the core for exactly r = floor(sqrt(x))
// cycles, which leaves the core back in its initial state. It then captures
// core_res_i and presents it on a valid/ready output stream.
//
// Parameters
//   MAX_ITER     guard limit on enable cycles per operand (>=16 for full range)
//
// Ports
//   clk_i        rising-edge clock
//   rstn_i       asynchronous active-low reset (shared with the core)
//   in_valid_i   operand valid
//   in_ready_o   operand accepted when in_valid_i && in_ready_o at posedge
//   in_data_i    operand x, unsigned 8-bit
//   core_enb_o   enable to the sqrt core
//   core_dt_o    registered operand to the core, changes only on accept
//   core_res_i   result from the core
//   out_valid_o  result valid, held under backpressure
//   out_ready_i  result consumed when out_valid_o && out_ready_i at posedge
//   out_data_o   result, stable while out_valid_o is high
//   busy_o       high in every state except IDLE
//   err_o        sticky error flag (only with SQRT_ISSUE_CHECK_EN)
//
// Build option
//   SQRT_ISSUE_CHECK_EN  when defined, adds err_o: set on a guard trip or when
//                        the core result disagrees with the shadow count.
module sqrt_issue_ctrl #(
  parameter int MAX_ITER = 16
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_data_i,
  output logic       core_enb_o,
  output logic [7:0] core_dt_o,
  input  logic [7:0] core_res_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
`ifdef SQRT_ISSUE_CHECK_EN
  output logic       err_o,
`endif
  output logic [7:0] out_data_o,
  output logic       busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, CAPT, HOLD} state_t;
  state_t      state_q, state_d;
  logic [4:0]  c_q, c_d;
  logic [9:0]  q_q, q_d;
  logic [7:0]  dt_q, dt_d;
  logic [7:0]  res_q, res_d;
  logic        accept, guard, step;
  // Shadow tracker: c counts enable cycles, q = (c+1)^2. While q <= x the
  // core still needs another cycle, so the enable count ends at floor(sqrt(x)).
  assign accept = (state_q == IDLE) && in_valid_i;
  assign guard  = (state_q == RUN) && (int'(c_q) >= MAX_ITER);
  assign step   = (state_q == RUN) && !guard && (q_q <= {2'b00, dt_q});
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !in_valid_i ? IDLE : (in_data_i == 8'd0) ? HOLD : RUN;
      RUN:     state_d = step ? RUN : CAPT;
      CAPT:    state_d = HOLD;
      HOLD:    state_d = out_ready_i ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    core_enb_o  = (state_q == RUN);
    out_valid_o = (state_q == HOLD);
    busy_o      = (state_q != IDLE);
    core_dt_o   = dt_q;
    out_data_o  = res_q;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      c_q   <= '0;
      q_q   <= '0;
      dt_q  <= '0;
      res_q <= '0;
    end else begin
      c_q   <= c_d;
      q_q   <= q_d;
      dt_q  <= dt_d;
      res_q <= res_d;
    end
  end
  always_comb begin
    dt_d  = accept ? in_data_i : dt_q;
    c_d   = accept ? 5'd1 : step ? c_q + 5'd1 : c_q;
    q_d   = accept ? 10'd4 : step ? q_q + {4'b0000, c_q, 1'b0} + 10'd3 : q_q;
    res_d = (accept && in_data_i == 8'd0) ? 8'd0 : (state_q == CAPT) ? core_res_i : res_q;
  end
`ifdef SQRT_ISSUE_CHECK_EN
  logic err_q, err_d;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) err_q <= 1'b0;
    else         err_q <= err_d;
  end
  // At CAPT the shadow count c equals floor(sqrt(x)), so it checks the core.
  always_comb begin
    err_d = err_q | guard | ((state_q == CAPT) && (core_res_i != {3'b000, c_q}));
  end
  assign err_o = err_q;
`endif
endmodule

// File: tb/tb_sqrt_issue_ctrl.sv
// tb_sqrt_issue_ctrl: randomized self-checking bench for sqrt_issue_ctrl.
module tb_sqrt_issue_ctrl;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       core_enb;
  logic [7:0] core_dt;
  logic [7:0] core_res;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;
`ifdef SQRT_ISSUE_CHECK_EN
  logic       err;
`endif
  int tests = 0;
  int fails = 0;
  // Core stand-in: reports how many consecutive enable cycles it received,
  // unless overridden to emulate a faulty core.
  logic [7:0] cnt;
  logic       prev_enb;
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'd0;
  always #5 clk = ~clk;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= 8'd0;
      prev_enb <= 1'b0;
    end else begin
      prev_enb <= core_enb;
      if (core_enb) cnt <= prev_enb ? cnt + 8'd1 : 8'd1;
    end
  end
  assign core_res = force_en ? force_val : cnt;
  sqrt_issue_ctrl #(.MAX_ITER(16)) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .in_data_i(in_data),
    .core_enb_o(core_enb),
    .core_dt_o(core_dt),
    .core_res_i(core_res),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
`ifdef SQRT_ISSUE_CHECK_EN
    .err_o(err),
`endif
    .out_data_o(out_data),
    .busy_o(busy)
  );
  function automatic int isqrt(input int x);
    int i = 0;
    while ((i + 1) * (i + 1) <= x) i++;
    return i;
  endfunction
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_enb"}, int'(core_enb), 0);
    check({tag, "_dt"}, int'(core_dt), 0);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_data"}, int'(out_data), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask
  // Called at a negedge with the DUT idle. Keeps in_valid high with a decoy
  // operand while busy, which must never be accepted.
  task automatic op(input int x, input int stall);
    int r = isqrt(x);
    int en = 0;
    bit seen = 0;
    check("pre_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    in_data = 8'(x);
    @(posedge clk);
    #1 in_data = 8'(x) ^ 8'hA5;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        check("latency", k, r == 0 ? 1 : r + 2);
      end else begin
        en += int'(core_enb);
        if (!busy || in_ready) check("busy_ready", {30'd0, busy, in_ready}, 2);
      end
    end
    if (!seen) check("timeout", 0, 1);
    check("enb_cycles", en, r);
    check("result", int'(out_data), r);
    check("dt_stable", int'(core_dt), x);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (!out_valid || out_data != 8'(r)) check("hold", {23'd0, out_valid, out_data}, {23'd1, 8'(r)});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    if (busy || !in_ready || core_dt != 8'(x)) check("after_hs", {22'd0, busy, in_ready, core_dt}, {23'd1, 8'(x)});
  endtask
  initial begin
    #12;
    check_reset("rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_reset("idle");
    op(1, 0);
    op(255, 3);
    op(0, 2);
    op(4, 0);
    op(3, 1);
    for (int x = 0; x < 256; x++) op(x, int'($urandom_range(0, 5)));
    for (int i = 0; i < 30; i++) op(int'($urandom_range(0, 255)), int'($urandom_range(0, 5)));
    // Reset in the middle of x=200: everything returns at once, no result.
    in_valid = 1'b1;
    in_data = 8'd200;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy", int'(busy), 1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 check_reset("async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_valid", int'(out_valid), 0);
    end
    rstn = 1'b1;
    @(negedge clk);
    check_reset("post_rst");
    op(16, 2);
`ifdef SQRT_ISSUE_CHECK_EN
    check("err_clean", int'(err), 0);
    force_en = 1'b1;
    force_val = 8'd3;
    in_valid = 1'b1;
    in_data = 8'd100;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check("err_pre", int'(err), 0);
    end
    @(negedge clk);
    check("err_set", int'(err), 1);
    check("err_data", int'(out_data), 3);
    check("err_valid", int'(out_valid), 1);
    force_en = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("err_sticky", int'(err), 1);
    rstn = 1'b0;
    #1 check("err_cleared", int'(err), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
